// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed ops iterate on magnitudes (shift-add / restoring division) and fix signs at commit.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(ITER);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  // Operand decode for the start cycle; sign flags only exist for signed ops.
  logic             in_div;
  logic             in_signed;
  logic             in_a_neg;
  logic             in_b_neg;
  logic [WIDTH-1:0] in_a_mag;
  logic [WIDTH-1:0] in_b_mag;

  assign in_div    = op[1];
  assign in_signed = ~op[0];
  assign in_a_neg  = in_signed & rs_data[WIDTH-1];
  assign in_b_neg  = in_signed & rt_data[WIDTH-1];
  assign in_a_mag  = in_a_neg ? -rs_data : rs_data;
  assign in_b_mag  = in_b_neg ? -rt_data : rt_data;

  // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opnd};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  assign acc_next = op_div ? div_next : mul_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod   = (a_neg ^ b_neg) ? -acc_next : acc_next;
  assign quo    = (a_neg ^ b_neg) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
  assign rem    = a_neg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
  assign res_hi = op_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = op_div ? quo : prod[WIDTH-1:0];

  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            busy <= 1'b1;
            if (in_div && (rt_data == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              state  <= RUN;
              cnt    <= '0;
              op_div <= in_div;
              a_neg  <= in_a_neg;
              b_neg  <= in_b_neg;
              opnd   <= in_div ? in_b_mag : in_a_mag;
              acc    <= {{WIDTH{1'b0}}, (in_div ? in_a_mag : in_b_mag)};
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule
